dijkstra: RTL and testbench

- Hardware shortest-path engine for the store-map pathfinding subsystem.
- On a start pulse it runs Dijkstra's algorithm from `start_node.node_id` to `goal_node.node_id` over a node graph held in an internal ROM.
- It then backtracks parent links and emits the path as (x,y) coordinates, goal first.
- Sits between the host/bus interface, which supplies endpoints and reads the path, and the node ROM.

---
 rtl/pathfinding_pkg.sv | 45 ++++
 rtl/node_rom.sv | 59 +++++
 rtl/dijkstra.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dijkstra.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pathfinding_pkg.sv
// Shared types for the store-map shortest-path engine.
//   coord      : one (x, y) path point, 16 bits each.
//   node_info  : one node ROM record, MSB first: x, y, node_id,
//                parent_node_id, current_cost, then six (child_id, distance) slots.
//   state_t    : search controller states.
//   INF        : "unreached" cost marker.
package pathfinding_pkg;

    localparam logic [15:0] INF       = 16'hFFFF;
    localparam logic [15:0] COST_MAX  = 16'hFFFE;
    localparam int          NUM_CHILD = 6;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } coord;

    typedef struct packed {
        logic [15:0] child_id;
        logic [15:0] distance;
    } child_t;

    // child[0] sits in the most significant slot.
    typedef struct packed {
        logic [15:0]                 x;
        logic [15:0]                 y;
        logic [15:0]                 node_id;
        logic [15:0]                 parent_node_id;
        logic [15:0]                 current_cost;
        child_t [0:NUM_CHILD-1]      child;
    } node_info;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        SELECT,
        FETCH,
        RELAX,
        BACKTRACK,
        BT_WRITE,
        DONE_OK,
        FAIL
    } state_t;

endpackage

// File: rtl/node_rom.sv
// Node graph ROM with one registered read port.
//   clk    : clock, rising edge
//   addr_i : node id to read
//   data_o : node_info record for addr_i, valid the cycle after addr_i is presented
// The contents are the built-in store map; NODE_FILE names that map image.
module node_rom
    import pathfinding_pkg::*;
#(
    parameter int    NUM_NODES = 256,
    parameter string NODE_FILE = "nodes.hex"
) (
    input  logic                         clk,
    input  logic [$clog2(NUM_NODES)-1:0] addr_i,
    output node_info                     data_o
);

    localparam int ID_W = $clog2(NUM_NODES);

    localparam bit unused_no_image = (NODE_FILE == "");

    function automatic node_info entry(input logic [ID_W-1:0] id);
        node_info e;
        e = '0;
        e.node_id = 16'(id);
        case (16'(id))
            16'h005A: begin
                e.x = 16'h0047;
                e.y = 16'h002C;
                e.child[0].child_id = 16'h0003;
                e.child[0].distance = 16'h002A;
                e.child[1].child_id = 16'h0013;
                e.child[1].distance = 16'h002E;
                e.child[2].child_id = 16'h0020;
                e.child[2].distance = 16'h00A5;
            end
            16'h0003: begin
                e.child[0].child_id = 16'h005B;
                e.child[0].distance = 16'h0010;
            end
            16'h0013: begin
                e.x = 16'h0050;
                e.y = 16'h0060;
                e.child[0].child_id = 16'h005B;
                e.child[0].distance = 16'h0005;
            end
            16'h005B: begin
                e.x = 16'h0041;
                e.y = 16'h0124;
            end
            default: e.node_id = 16'(id);
        endcase
        return e;
    endfunction

    always_ff @(posedge clk) begin
        data_o <= entry(addr_i);
    end

endmodule

// File: rtl/dijkstra.sv
// Dijkstra shortest-path engine over the node ROM.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   start      : start request, taken in IDLE / DONE_OK / FAIL
//   start_node : source node (node_id only)
//   goal_node  : destination node (node_id only)
//   path       : path coordinates, path[0] = goal ... path[i-1] = start
//   i          : number of valid path entries
//   success    : complete path present
//   done       : search finished (pass or fail)
module dijkstra
    import pathfinding_pkg::*;
#(
    parameter int    NUM_NODES = 256,
    parameter int    MAX_PATH  = 100,
    parameter string NODE_FILE = "nodes.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  node_info    start_node,
    input  node_info    goal_node,
    output coord        path [0:MAX_PATH-1],
    output logic [15:0] i,
    output logic        success,
    output logic        done
);

    localparam int ID_W    = $clog2(NUM_NODES);
    localparam int PATH_AW = $clog2(MAX_PATH);

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, COST_MAX}) ? COST_MAX : s[15:0];
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       s_id_q, s_id_d, g_id_q, g_id_d;
    logic [ID_W-1:0]   scan_q, scan_d;
    logic [ID_W-1:0]   best_id_q, best_id_d;
    logic [15:0]       best_cost_q, best_cost_d;
    logic [ID_W-1:0]   u_q, u_d;
    logic [15:0]       u_cost_q, u_cost_d;
    logic [2:0]        slot_q, slot_d;
    logic [ID_W-1:0]   n_q, n_d;
    logic [15:0]       i_q, i_d;
    logic              success_q, success_d, done_q, done_d;
    coord              path_q [0:MAX_PATH-1];

    logic [15:0]       cost_q    [NUM_NODES];
    logic [ID_W-1:0]   parent_q  [NUM_NODES];
    logic [NUM_NODES-1:0] visited_q;

    node_info          rom_data;
    logic [ID_W-1:0]   rom_addr;
    logic              path_we;
    coord              path_wdata;

    node_rom #(
        .NUM_NODES (NUM_NODES),
        .NODE_FILE (NODE_FILE)
    ) u_rom (
        .clk    (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    logic unused_bits;
    assign unused_bits = ^{start_node.x, start_node.y, start_node.parent_node_id,
                           start_node.current_cost, start_node.child,
                           goal_node.x, goal_node.y, goal_node.parent_node_id,
                           goal_node.current_cost, goal_node.child,
                           rom_data.node_id, rom_data.parent_node_id, rom_data.current_cost};

    // Shared scan end, endpoint validity
    logic last_scan, ends_ok;
    assign last_scan = (scan_q == ID_W'(NUM_NODES - 1));
    assign ends_ok   = (s_id_q != 16'd0) && (s_id_q < 16'(NUM_NODES)) &&
                       (g_id_q != 16'd0) && (g_id_q < 16'(NUM_NODES));

    // SELECT: strict '<' keeps the lowest id on ties; best_cost starts at INF
    // so only reached nodes ever qualify.
    logic            sel_cand, sel_found;
    logic [ID_W-1:0] sel_id;
    logic [15:0]     sel_cost;
    assign sel_cand  = !visited_q[scan_q] && (cost_q[scan_q] < best_cost_q);
    assign sel_id    = sel_cand ? scan_q : best_id_q;
    assign sel_cost  = sel_cand ? cost_q[scan_q] : best_cost_q;
    assign sel_found = (sel_cost != INF);

    // RELAX: one child slot of ROM[u] per cycle
    child_t          slot;
    logic [ID_W-1:0] c_idx;
    logic [15:0]     nc;
    logic            c_ok, relax_upd;
    assign slot      = rom_data.child[slot_q];
    assign c_idx     = slot.child_id[ID_W-1:0];
    assign c_ok      = (slot.child_id != 16'd0) && (slot.child_id < 16'(NUM_NODES)) &&
                       !visited_q[c_idx];
    assign nc        = sat_add(u_cost_q, slot.distance);
    assign relax_upd = (state_q == RELAX) && c_ok && (nc < cost_q[c_idx]);

    // BACKTRACK: full means the entry being written is the last one that fits
    logic bt_at_start, bt_full;
    assign bt_at_start = (n_q == s_id_q[ID_W-1:0]);
    assign bt_full     = ((i_q + 16'd1) >= 16'(MAX_PATH));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE_OK, FAIL: if (start) state_d = INIT;
            INIT:      if (last_scan) state_d = ends_ok ? SELECT : FAIL;
            SELECT: begin
                if (last_scan) begin
                    if (!sel_found)                 state_d = FAIL;
                    else if (16'(sel_id) == g_id_q) state_d = BACKTRACK;
                    else                            state_d = FETCH;
                end
            end
            FETCH:     state_d = RELAX;
            RELAX:     if (slot_q == 3'(NUM_CHILD - 1)) state_d = SELECT;
            BACKTRACK: state_d = BT_WRITE;
            BT_WRITE: begin
                if (bt_at_start)  state_d = DONE_OK;
                else if (bt_full) state_d = FAIL;
                else              state_d = BACKTRACK;
            end
            default:   state_d = IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        rom_addr   = (state_q == BACKTRACK || state_q == BT_WRITE) ? n_q : u_q;
        path_we    = (state_q == BT_WRITE);
        path_wdata = '{x: rom_data.x, y: rom_data.y};
        done_d     = (state_d == DONE_OK) || (state_d == FAIL);
        success_d  = (state_d == DONE_OK);
    end

    // Search bookkeeping next-state
    always_comb begin
        s_id_d      = s_id_q;
        g_id_d      = g_id_q;
        scan_d      = scan_q;
        best_id_d   = best_id_q;
        best_cost_d = best_cost_q;
        u_d         = u_q;
        u_cost_d    = u_cost_q;
        slot_d      = slot_q;
        n_d         = n_q;
        i_d         = i_q;
        unique case (state_q)
            IDLE, DONE_OK, FAIL: begin
                if (start) begin
                    s_id_d = start_node.node_id;
                    g_id_d = goal_node.node_id;
                    scan_d = '0;
                    i_d    = '0;
                end
            end
            INIT: begin
                scan_d = scan_q + ID_W'(1);
                if (last_scan) begin
                    scan_d      = ID_W'(1);
                    best_id_d   = '0;
                    best_cost_d = INF;
                end
            end
            SELECT: begin
                if (last_scan) begin
                    u_d      = sel_id;
                    u_cost_d = sel_cost;
                    n_d      = sel_id;
                end else begin
                    scan_d      = scan_q + ID_W'(1);
                    best_id_d   = sel_id;
                    best_cost_d = sel_cost;
                end
            end
            FETCH: slot_d = '0;
            RELAX: begin
                slot_d = slot_q + 3'd1;
                if (slot_q == 3'(NUM_CHILD - 1)) begin
                    scan_d      = ID_W'(1);
                    best_id_d   = '0;
                    best_cost_d = INF;
                end
            end
            BT_WRITE: begin
                i_d = i_q + 16'd1;
                if (!bt_at_start) n_d = parent_q[n_q];
            end
            default: ;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_id_q      <= '0;
            g_id_q      <= '0;
            scan_q      <= '0;
            best_id_q   <= '0;
            best_cost_q <= INF;
            u_q         <= '0;
            u_cost_q    <= '0;
            slot_q      <= '0;
            n_q         <= '0;
            i_q         <= '0;
            success_q   <= 1'b0;
            done_q      <= 1'b0;
            for (int k = 0; k < MAX_PATH; k++) path_q[k] <= '0;
        end else begin
            s_id_q      <= s_id_d;
            g_id_q      <= g_id_d;
            scan_q      <= scan_d;
            best_id_q   <= best_id_d;
            best_cost_q <= best_cost_d;
            u_q         <= u_d;
            u_cost_q    <= u_cost_d;
            slot_q      <= slot_d;
            n_q         <= n_d;
            i_q         <= i_d;
            success_q   <= success_d;
            done_q      <= done_d;
            if (path_we) path_q[i_q[PATH_AW-1:0]] <= path_wdata;
        end
    end

    // Search tables: fully rewritten by INIT before every search, so no reset.
    // cost[S]=0 is issued after the INIT clear so it wins when S is the last id.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            cost_q[scan_q]    <= INF;
            parent_q[scan_q]  <= '0;
            visited_q[scan_q] <= 1'b0;
            if (last_scan && ends_ok) cost_q[s_id_q[ID_W-1:0]] <= '0;
        end
        if (state_q == SELECT && last_scan && sel_found) visited_q[sel_id] <= 1'b1;
        if (relax_upd) begin
            cost_q[c_idx]   <= nc;
            parent_q[c_idx] <= u_q;
        end
    end

    assign path    = path_q;
    assign i       = i_q;
    assign success = success_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dijkstra.sv
module tb_dijkstra;
    import pathfinding_pkg::*;

    localparam int NUM_NODES = 256;
    localparam int MAX_PATH  = 100;
    localparam int BUDGET    = 5000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    node_info    start_node = '0;
    node_info    goal_node = '0;
    coord        path [0:MAX_PATH-1];
    logic [15:0] i;
    logic        success;
    logic        done;

    int errors = 0;
    int checks = 0;

    dijkstra #(
        .NUM_NODES (NUM_NODES),
        .MAX_PATH  (MAX_PATH),
        .NODE_FILE ("nodes.hex")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_node (start_node),
        .goal_node  (goal_node),
        .path       (path),
        .i          (i),
        .success    (success),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] s_id;
        logic [15:0] g_id;
        logic        exp_ok;
        logic [15:0] exp_len;
        coord        p0;
        coord        p1;
        coord        p2;
    } vec_t;

    vec_t vecs [8];

    function automatic coord xy(input logic [15:0] x, input logic [15:0] y);
        coord c;
        c.x = x;
        c.y = y;
        return c;
    endfunction

    function automatic vec_t mk(input logic [15:0] s, input logic [15:0] g, input logic ok,
                                input logic [15:0] len, input coord p0, input coord p1,
                                input coord p2);
        vec_t v;
        v.s_id = s; v.g_id = g; v.exp_ok = ok; v.exp_len = len;
        v.p0 = p0; v.p1 = p1; v.p2 = p2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse (or hold for `hold` cycles) start, then wait for done.
    task automatic run_search(input logic [15:0] s, input logic [15:0] g, input int hold,
                              output int cycles);
        start_node = '0;
        goal_node  = '0;
        start_node.node_id = s;
        goal_node.node_id  = g;
        start = 1'b1;
        tick();
        cycles = 0;
        while (!done && cycles < BUDGET) begin
            if (cycles + 1 >= hold) start = 1'b0;
            tick();
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic check_vec(input string tag, input vec_t v, input int cycles);
        coord expc;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_success"}, 32'(success), 32'(v.exp_ok));
        check({tag, "_len"}, 32'(i), 32'(v.exp_len));
        for (int k = 0; k < 3; k++) begin
            if (k < int'(v.exp_len)) begin
                expc = (k == 0) ? v.p0 : (k == 1) ? v.p1 : v.p2;
                check($sformatf("%s_path%0d", tag, k), path[k], expc);
            end
        end
        if (v.s_id == 16'd0 || v.s_id >= 16'(NUM_NODES) ||
            v.g_id == 16'd0 || v.g_id >= 16'(NUM_NODES))
            check({tag, "_bad_endpoint_latency"}, 32'(cycles <= NUM_NODES + 2), 32'd1);
    endtask

    initial begin
        int cyc;
        int waited;

        vecs[0] = mk(16'h5A, 16'h5B, 1'b1, 16'd3, xy(16'h41, 16'h124), xy(16'h50, 16'h60), xy(16'h47, 16'h2C));
        vecs[1] = mk(16'h5A, 16'h5A, 1'b1, 16'd1, xy(16'h47, 16'h2C), '0, '0);
        vecs[2] = mk(16'h5A, 16'h30, 1'b0, 16'd0, '0, '0, '0);
        vecs[3] = mk(16'h00, 16'h5B, 1'b0, 16'd0, '0, '0, '0);
        vecs[4] = mk(16'h5A, 16'h100, 1'b0, 16'd0, '0, '0, '0);
        vecs[5] = mk(16'h13, 16'h5B, 1'b1, 16'd2, xy(16'h41, 16'h124), xy(16'h50, 16'h60), '0);
        vecs[6] = mk(16'h5B, 16'h5A, 1'b0, 16'd0, '0, '0, '0);
        vecs[7] = mk(16'h5A, 16'h20, 1'b1, 16'd2, xy(16'h00, 16'h00), xy(16'h47, 16'h2C), '0);

        // Reset state
        #3 reset = 1'b0;
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_success", 32'(success), 32'd0);
        check("rst_len", 32'(i), 32'd0);
        check("rst_path0", path[0], 32'd0);
        check("rst_path99", path[MAX_PATH-1], 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            run_search(vecs[v].s_id, vecs[v].g_id, 1, cyc);
            check_vec($sformatf("vec%0d", v), vecs[v], cyc);
        end

        // Entries beyond i keep the earlier search's contents
        check("stale_path2", path[2], xy(16'h47, 16'h2C));

        // Reset in the middle of RELAX
        start_node = '0;
        goal_node  = '0;
        start_node.node_id = 16'h5A;
        goal_node.node_id  = 16'h5B;
        start = 1'b1;
        tick();
        start = 1'b0;
        waited = 0;
        while (dut.state_q != RELAX && waited < BUDGET) begin
            tick();
            waited++;
        end
        check("reach_relax", 32'(dut.state_q == RELAX), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_success", 32'(success), 32'd0);
        check("midrst_len", 32'(i), 32'd0);
        check("midrst_path1", path[1], 32'd0);
        check("midrst_path2", path[2], 32'd0);
        tick();
        reset = 1'b1;
        tick();
        run_search(16'h5A, 16'h5B, 1, cyc);
        check_vec("after_rst", vecs[0], cyc);

        // start held high through most of the search
        run_search(16'h5A, 16'h5B, 500, cyc);
        check_vec("held_start", vecs[0], cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
